seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_to_bcd.sv | 30 +++
 rtl/seg7_scan_decoder.sv | 185 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns,
// output codes, digit count and the tracking FSM state type.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [3:0] CODE_BLANK   = 4'hA;
  localparam logic [3:0] CODE_ILLEGAL = 4'hF;

  // Active-low segment patterns, bit6 = a ... bit0 = g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  function automatic logic sel_is_single(input logic [NUM_DIGITS-1:0] sel_n);
    return ($countones(~sel_n) == 1);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern lookup: returns the digit code, blank code,
// or the illegal code with its flag for any unrecognised pattern.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_illegal
);

  always_comb begin
    o_code    = CODE_ILLEGAL;
    o_illegal = 1'b1;
    case (i_seg)
      SEG_0:     begin o_code = 4'd0;       o_illegal = 1'b0; end
      SEG_1:     begin o_code = 4'd1;       o_illegal = 1'b0; end
      SEG_2:     begin o_code = 4'd2;       o_illegal = 1'b0; end
      SEG_3:     begin o_code = 4'd3;       o_illegal = 1'b0; end
      SEG_4:     begin o_code = 4'd4;       o_illegal = 1'b0; end
      SEG_5:     begin o_code = 4'd5;       o_illegal = 1'b0; end
      SEG_6:     begin o_code = 4'd6;       o_illegal = 1'b0; end
      SEG_7:     begin o_code = 4'd7;       o_illegal = 1'b0; end
      SEG_8:     begin o_code = 4'd8;       o_illegal = 1'b0; end
      SEG_9:     begin o_code = 4'd9;       o_illegal = 1'b0; end
      SEG_BLANK: begin o_code = CODE_BLANK; o_illegal = 1'b0; end
      default:   begin o_code = CODE_ILLEGAL; o_illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Debounces a multiplexed 6-digit seven-segment scan into per-digit codes and
// hands out complete snapshots over a valid/ready handshake.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     dig_sel_n,
  output logic [4*NUM_DIGITS-1:0]   digit_bcd,
  output logic [NUM_DIGITS-1:0]     digit_err,
  output logic                      frame_valid,
  output logic [4*NUM_DIGITS-1:0]   frame_bcd,
  input  logic                      frame_ready
);

  localparam logic [7:0]  STABLE_CNT = 8'(STABLE_CYCLES);
  localparam logic [23:0] BLANK_ALL  = {NUM_DIGITS{CODE_BLANK}};

  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [6:0]            r_st_seg;
  logic [NUM_DIGITS-1:0] r_st_sel;
  state_t                r_state;
  logic [7:0]            r_count;
  logic [23:0]           r_digit_bcd;
  logic [NUM_DIGITS-1:0] r_digit_err;
  logic [NUM_DIGITS-1:0] r_mask;
  logic                  r_frame_valid;
  logic [23:0]           r_frame_bcd;

  state_t                w_state_nxt;
  logic [7:0]            w_count_nxt;
  logic                  w_commit;
  logic                  w_store;
  logic                  w_clear;
  logic                  w_sel_ok;
  logic                  w_pair_new;
  logic [3:0]            w_code;
  logic                  w_illegal;
  logic [NUM_DIGITS-1:0] w_commit_mask;
  logic [23:0]           w_digit_bcd_nxt;
  logic [NUM_DIGITS-1:0] w_digit_err_nxt;
  logic [NUM_DIGITS-1:0] w_mask_nxt;
  logic                  w_mask_full;

  seg7_to_bcd u_lookup (
    .i_seg     (r_seg),
    .o_code    (w_code),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= '1;
      r_sel <= '1;
    end else begin
      r_seg <= seg_in;
      r_sel <= dig_sel_n;
    end
  end

  assign w_sel_ok   = sel_is_single(r_sel);
  assign w_pair_new = (r_seg != r_st_seg) || (r_sel != r_st_sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // The stored pair is wiped on IDLE so any later valid select restarts tracking.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_commit    = 1'b0;
    w_store     = 1'b0;
    w_clear     = 1'b0;
    if (!w_sel_ok) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
      w_clear     = 1'b1;
    end else if (w_pair_new) begin
      w_store     = 1'b1;
      w_count_nxt = 8'd1;
      w_state_nxt = ST_TRACK;
    end else begin
      case (r_state)
        ST_TRACK: begin
          if (r_count < STABLE_CNT) w_count_nxt = r_count + 8'd1;
          if (r_count + 8'd1 == STABLE_CNT) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_HELD;
          end
        end
        ST_HELD: begin
          w_count_nxt = r_count;
        end
        default: begin
          w_store     = 1'b1;
          w_count_nxt = 8'd1;
          w_state_nxt = ST_TRACK;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st_seg <= '1;
      r_st_sel <= '1;
    end else if (w_clear) begin
      r_st_seg <= '1;
      r_st_sel <= '1;
    end else if (w_store) begin
      r_st_seg <= r_seg;
      r_st_sel <= r_sel;
    end
  end

  assign w_commit_mask = w_commit ? ~r_sel : '0;

  always_comb begin
    w_digit_bcd_nxt = r_digit_bcd;
    w_digit_err_nxt = r_digit_err;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_commit_mask[i]) begin
        w_digit_bcd_nxt[i*4 +: 4] = w_code;
        w_digit_err_nxt[i]        = w_illegal;
      end
    end
  end

  assign w_mask_nxt  = r_mask | w_commit_mask;
  assign w_mask_full = &w_mask_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit_bcd <= BLANK_ALL;
      r_digit_err <= '0;
    end else begin
      r_digit_bcd <= w_digit_bcd_nxt;
      r_digit_err <= w_digit_err_nxt;
    end
  end

  // A full mask seen while a snapshot is outstanding is held until the handshake edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask        <= '0;
      r_frame_valid <= 1'b0;
      r_frame_bcd   <= BLANK_ALL;
    end else if (r_frame_valid) begin
      if (frame_ready) begin
        if (w_mask_full) begin
          r_frame_bcd <= w_digit_bcd_nxt;
          r_mask      <= '0;
        end else begin
          r_frame_valid <= 1'b0;
          r_mask        <= w_mask_nxt;
        end
      end else begin
        r_mask <= w_mask_nxt;
      end
    end else if (w_mask_full) begin
      r_frame_bcd   <= w_digit_bcd_nxt;
      r_frame_valid <= 1'b1;
      r_mask        <= '0;
    end else begin
      r_mask <= w_mask_nxt;
    end
  end

  assign digit_bcd   = r_digit_bcd;
  assign digit_err   = r_digit_err;
  assign frame_valid = r_frame_valid;
  assign frame_bcd   = r_frame_bcd;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed vectors and sequences, then random scans
// compared every cycle against a sample-history reference model.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_in;
  logic [5:0]  dig_sel_n;
  logic [23:0] digit_bcd;
  logic [5:0]  digit_err;
  logic        frame_valid;
  logic [23:0] frame_bcd;
  logic        frame_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .dig_sel_n   (dig_sel_n),
    .digit_bcd   (digit_bcd),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_bcd   (frame_bcd),
    .frame_ready (frame_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input logic [5:0] sel, input logic [6:0] seg);
    dig_sel_n = sel;
    seg_in    = seg;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    frame_ready = 1'b0;
    apply(6'h3F, 7'h7F);
    step(2);
    reset = 1'b0;
  endtask

  // Reference decode straight from the pattern table: {error, code}
  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h00;
      7'b1001111: return 5'h01;
      7'b0010010: return 5'h02;
      7'b0000110: return 5'h03;
      7'b1001100: return 5'h04;
      7'b0100100: return 5'h05;
      7'b0100000: return 5'h06;
      7'b0001111: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0000100: return 5'h09;
      7'b1111111: return 5'h0A;
      default:    return 5'h1F;
    endcase
  endfunction

  // Reference model: a digit commits on the edge where the last S registered
  // samples are one identical single-select pair that was not already S long.
  logic [12:0] hist[$];
  logic [12:0] m_reg;
  logic [23:0] m_bcd;
  logic [5:0]  m_err;
  logic [5:0]  m_mask;
  logic        m_fv;
  logic [23:0] m_fbcd;

  always @(posedge clk or posedge reset) begin : mdl
    logic [12:0] d;
    logic        commit;
    logic [23:0] bcd;
    logic [5:0]  err;
    logic [5:0]  nmask;
    logic [4:0]  dec;
    if (reset) begin
      hist.delete();
      m_reg  <= 13'h1FFF;
      m_bcd  <= 24'hAAAAAA;
      m_err  <= '0;
      m_mask <= '0;
      m_fv   <= 1'b0;
      m_fbcd <= 24'hAAAAAA;
    end else begin
      d = m_reg;
      hist.push_front(d);
      if (hist.size() > S + 1) void'(hist.pop_back());
      commit = ($countones(~d[12:7]) == 1) && (hist.size() >= S);
      for (int i = 0; i < S; i++)
        if (i < hist.size() && hist[i] != d) commit = 1'b0;
      if (hist.size() > S && hist[S] == d) commit = 1'b0;
      bcd   = m_bcd;
      err   = m_err;
      nmask = m_mask;
      dec   = ref_decode(d[6:0]);
      if (commit) begin
        for (int i = 0; i < 6; i++) begin
          if (!d[7+i]) begin
            bcd[i*4 +: 4] = dec[3:0];
            err[i]        = dec[4];
            nmask[i]      = 1'b1;
          end
        end
      end
      if (m_fv && frame_ready) begin
        if (&nmask) begin
          m_fbcd <= bcd;
          m_mask <= '0;
        end else begin
          m_fv   <= 1'b0;
          m_mask <= nmask;
        end
      end else if (!m_fv && &nmask) begin
        m_fbcd <= bcd;
        m_fv   <= 1'b1;
        m_mask <= '0;
      end else begin
        m_mask <= nmask;
      end
      m_bcd <= bcd;
      m_err <= err;
      m_reg <= {dig_sel_n, seg_in};
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("mdl_digit_bcd", 32'(digit_bcd), 32'(m_bcd));
      check("mdl_digit_err", 32'(digit_err), 32'(m_err));
      check("mdl_frame_valid", 32'(frame_valid), 32'(m_fv));
      check("mdl_frame_bcd", 32'(frame_bcd), 32'(m_fbcd));
    end
  end

  typedef struct {
    logic [6:0] seg;
    logic [3:0] code;
    logic       err;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{7'b0000001, 4'h0, 1'b0};
    tbl[1]  = '{7'b1001111, 4'h1, 1'b0};
    tbl[2]  = '{7'b0010010, 4'h2, 1'b0};
    tbl[3]  = '{7'b0000110, 4'h3, 1'b0};
    tbl[4]  = '{7'b1001100, 4'h4, 1'b0};
    tbl[5]  = '{7'b0100100, 4'h5, 1'b0};
    tbl[6]  = '{7'b0100000, 4'h6, 1'b0};
    tbl[7]  = '{7'b0001111, 4'h7, 1'b0};
    tbl[8]  = '{7'b0000000, 4'h8, 1'b0};
    tbl[9]  = '{7'b0000100, 4'h9, 1'b0};
    tbl[10] = '{7'b1111111, 4'hA, 1'b0};
    tbl[11] = '{7'b1110000, 4'hF, 1'b1};
    tbl[12] = '{7'b0110110, 4'hF, 1'b1};

    reset       = 1'b1;
    frame_ready = 1'b0;
    apply(6'h3F, 7'h7F);
    step(2);
    check("rst_digit_bcd", 32'(digit_bcd), 32'h00AAAAAA);
    check("rst_digit_err", 32'(digit_err), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_frame_bcd", 32'(frame_bcd), 32'h00AAAAAA);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Commit latency: visible after edge S+1, not after edge S
    apply(6'b111110, 7'b0100100);
    step(S);
    check("lat_not_yet", 32'(digit_bcd[3:0]), 32'hA);
    step(1);
    check("lat_commit", 32'(digit_bcd[3:0]), 32'h5);

    // Two-cycle glitch to 8 restarts the count
    apply(6'b111101, 7'b0100100);
    step(2);
    apply(6'b111101, 7'b0000000);
    step(2);
    apply(6'b111101, 7'b0100100);
    step(4);
    check("glitch_no_commit", 32'(digit_bcd[7:4]), 32'hA);
    step(1);
    check("glitch_commit5", 32'(digit_bcd[7:4]), 32'h5);

    // Illegal pattern on digit 2
    apply(6'b111011, 7'b1110000);
    step(6);
    check("illegal_code", 32'(digit_bcd[11:8]), 32'hF);
    check("illegal_err", 32'(digit_err[2]), 32'h1);

    for (int i = 0; i < 13; i++) begin
      apply(6'b111110, tbl[i].seg);
      step(S + 2);
      check($sformatf("tbl%0d_code", i), 32'(digit_bcd[3:0]), 32'(tbl[i].code));
      check($sformatf("tbl%0d_err", i), 32'(digit_err[0]), 32'(tbl[i].err));
    end

    // Full scan 1,2,3,4,5,9 from digit 5 down to digit 0
    do_reset();
    begin
      logic [6:0] scan [6];
      scan[0] = 7'b1001111;
      scan[1] = 7'b0010010;
      scan[2] = 7'b0000110;
      scan[3] = 7'b1001100;
      scan[4] = 7'b0100100;
      scan[5] = 7'b0000100;
      for (int k = 0; k < 6; k++) begin
        apply(~(6'b100000 >> k), scan[k]);
        step(6);
      end
    end
    check("frame_valid_set", 32'(frame_valid), 32'h1);
    check("frame_bcd", 32'(frame_bcd), 32'h00123459);
    apply(6'h3F, 7'h7F);
    step(3);
    check("frame_held_valid", 32'(frame_valid), 32'h1);
    check("frame_held_bcd", 32'(frame_bcd), 32'h00123459);
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    check("frame_released", 32'(frame_valid), 32'h0);

    // Invalid selects keep everything idle
    do_reset();
    apply(6'b111100, 7'b0100100);
    step(6);
    check("two_sel_bcd", 32'(digit_bcd), 32'h00AAAAAA);
    apply(6'b111111, 7'b0100100);
    step(6);
    check("no_sel_bcd", 32'(digit_bcd), 32'h00AAAAAA);
    check("no_sel_err", 32'(digit_err), 32'h0);

    // Asynchronous reset in the middle of tracking
    apply(6'b111110, 7'b0000110);
    step(6);
    check("pre_rst_commit", 32'(digit_bcd[3:0]), 32'h3);
    apply(6'b111101, 7'b0001111);
    step(3);
    reset = 1'b1;
    #1;
    check("async_digit_bcd", 32'(digit_bcd), 32'h00AAAAAA);
    check("async_digit_err", 32'(digit_err), 32'h0);
    check("async_frame_valid", 32'(frame_valid), 32'h0);
    check("async_frame_bcd", 32'(frame_bcd), 32'h00AAAAAA);
    apply(6'h3F, 7'h7F);
    @(posedge clk);
    #1;
    step(1);
    reset = 1'b0;
    step(8);
    check("post_rst_no_commit", 32'(digit_bcd), 32'h00AAAAAA);
    check("post_rst_no_frame", 32'(frame_valid), 32'h0);

    // Random scans against the model
    for (int b = 0; b < 400; b++) begin
      int r;
      logic [5:0] sel;
      logic [6:0] seg;
      r = $urandom_range(0, 9);
      if (r < 7)       sel = ~(6'd1 << $urandom_range(0, 5));
      else if (r == 7) sel = 6'h3F;
      else             sel = 6'($urandom);
      if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
      else                           seg = tbl[$urandom_range(0, 12)].seg;
      apply(sel, seg);
      repeat ($urandom_range(1, 8)) begin
        frame_ready = ($urandom_range(0, 2) == 0);
        step(1);
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
